// File: rtl/i2c_seq_pkg.sv
// Shared encodings for the I2C register sequencer: FSM states, step codes,
// response error codes, master status bit positions and the request record.
package i2c_seq_pkg;

    // Sequencer FSM states
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_DONE = 3'd2;
    localparam logic [2:0] S_NEXT      = 3'd3;
    localparam logic [2:0] S_RESP      = 3'd4;

    // Master steps; a write runs START_W, REG, DATA, STOP and a read runs
    // START_W, REG, START_R, STOP
    localparam logic [2:0] STEP_START_W = 3'd0;
    localparam logic [2:0] STEP_REG     = 3'd1;
    localparam logic [2:0] STEP_DATA    = 3'd2;
    localparam logic [2:0] STEP_START_R = 3'd3;
    localparam logic [2:0] STEP_STOP    = 3'd4;

    // Response error codes
    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_ADDR_NACK = 2'b01;
    localparam logic [1:0] ERR_DATA_NACK = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

    // Bit positions inside i_status
    localparam int ST_NACK_ADDR = 3;
    localparam int ST_NACK_DATA = 2;
    localparam int ST_TIP       = 1;
    localparam int ST_DRDY      = 0;

    typedef struct packed {
        logic       rw;
        logic [6:0] dev;
        logic [7:0] reg_a;
        logic [7:0] wdata;
    } req_t;

    // Step that follows s; the register step forks on read/write
    function automatic logic [2:0] next_step(input logic [2:0] s, input logic rw);
        case (s)
            STEP_START_W: next_step = STEP_REG;
            STEP_REG:     next_step = rw ? STEP_START_R : STEP_DATA;
            default:      next_step = STEP_STOP;
        endcase
    endfunction

    // Byte presented to the master for a given step
    function automatic logic [7:0] step_byte(input logic [2:0] s, input req_t r);
        case (s)
            STEP_START_W: step_byte = {r.dev, 1'b0};
            STEP_REG:     step_byte = r.reg_a;
            STEP_DATA:    step_byte = r.wdata;
            STEP_START_R: step_byte = {r.dev, 1'b1};
            default:      step_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/i2c_seq_timer.sv
// Per-step watchdog: reloaded when a step is issued, counts while the step
// is outstanding, flags expiry when the step has used up its budget.
module i2c_seq_timer #(
    parameter int             W   = 16,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);
    // cnt is the number of cycles already spent in the step, including the current one
    logic [W-1:0] cnt;

    // Reload to 1 so the first outstanding cycle counts; saturate at expiry
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= W'(1);
        else if (enable && !expired)
            cnt <= cnt + W'(1);
    end

    assign expired = enable && (cnt == MAX);

endmodule

// File: rtl/i2c_reg_seq.sv
// I2C register read/write sequencer: turns one register request into a
// START/RW/STOP strobe sequence for a byte-level I2C master and reports
// completion with read data and an error code.
module i2c_reg_seq
    import i2c_seq_pkg::*;
#(
    parameter int                   TIMEOUT_W   = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 16'hFFFF
) (
    input  logic       m_clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_err,
    output logic [7:0] o_addr_cmd_data,
    output logic       o_start,
    output logic       o_rw_data,
    output logic       o_stop,
    input  logic [3:0] i_status,
    input  logic [7:0] i_data
);
    logic [2:0] state, step, nstep;
    req_t       req;
    logic [7:0] data_q;
    logic [1:0] err_q;
    logic       tmr_load, tmr_en, tmr_expired;
    logic       nack_a, nack_d, tip, drdy;
    logic       accept, rd_miss, adv;

    assign nack_a = i_status[ST_NACK_ADDR];
    assign nack_d = i_status[ST_NACK_DATA];
    assign tip    = i_status[ST_TIP];
    assign drdy   = i_status[ST_DRDY];

    assign accept  = (state == S_IDLE) && req_valid;
    assign rd_miss = (step == STEP_START_R) && !drdy;
    assign nstep   = next_step(step, req.rw);
    // NEXT moves on to another step only when the finished step was clean
    assign adv     = (state == S_NEXT) && (step != STEP_STOP) && !nack_a && !nack_d && !rd_miss;

    assign tmr_load = accept || adv;
    assign tmr_en   = (state == S_ISSUE) || (state == S_WAIT_DONE);

    i2c_seq_timer #(.W(TIMEOUT_W), .MAX(TIMEOUT_MAX)) u_timer (
        .clk     (m_clk),
        .reset   (reset),
        .load    (tmr_load),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    // Strobes decode straight from state so they vanish the cycle ISSUE is left
    assign o_start   = (state == S_ISSUE) && ((step == STEP_START_W) || (step == STEP_START_R));
    assign o_rw_data = (state == S_ISSUE) && ((step == STEP_REG) || (step == STEP_DATA));
    assign o_stop    = (state == S_ISSUE) && (step == STEP_STOP);

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

    // Sequencer FSM: step through master operations, collect status, respond
    always_ff @(posedge m_clk) begin
        if (reset) begin
            state           <= S_IDLE;
            step            <= STEP_START_W;
            req             <= '0;
            o_addr_cmd_data <= 8'h00;
            data_q          <= 8'h00;
            err_q           <= ERR_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req             <= '{rw: req_rw, dev: dev_addr, reg_a: reg_addr, wdata: wr_data};
                        step            <= STEP_START_W;
                        o_addr_cmd_data <= {dev_addr, 1'b0};
                        data_q          <= 8'h00;
                        err_q           <= ERR_OK;
                        state           <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT_DONE: begin
                    if (tmr_expired) begin
                        err_q  <= ERR_TIMEOUT;
                        data_q <= 8'h00;
                        state  <= S_RESP;
                    end else if ((state == S_ISSUE) && tip) begin
                        state <= S_WAIT_DONE;
                    end else if ((state == S_WAIT_DONE) && !tip) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    // STOP always completes clean; aborts skip STOP since the
                    // master returns to idle on its own after a NACK
                    if (step == STEP_STOP) begin
                        state <= S_RESP;
                    end else if (nack_a) begin
                        err_q  <= ERR_ADDR_NACK;
                        data_q <= 8'h00;
                        state  <= S_RESP;
                    end else if (nack_d || rd_miss) begin
                        err_q  <= ERR_DATA_NACK;
                        data_q <= 8'h00;
                        state  <= S_RESP;
                    end else begin
                        if (step == STEP_START_R)
                            data_q <= i_data;
                        step            <= nstep;
                        o_addr_cmd_data <= step_byte(nstep, req);
                        state           <= S_ISSUE;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Directed bench for i2c_reg_seq with a behavioural byte-level I2C master.
module tb_i2c_reg_seq;
    logic       m_clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0, req_rw = 1'b0;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_addr = '0, wr_data = '0;
    logic       req_ready, rsp_valid, o_start, o_rw_data, o_stop;
    logic [7:0] rsp_data, o_addr_cmd_data, i_data;
    logic [1:0] rsp_err;
    logic [3:0] i_status;

    int checks = 0, failures = 0;
    int cyc = 0;

    i2c_reg_seq #(.TIMEOUT_W(16), .TIMEOUT_MAX(16'h0020)) dut (
        .m_clk(m_clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .o_addr_cmd_data(o_addr_cmd_data), .o_start(o_start), .o_rw_data(o_rw_data),
        .o_stop(o_stop), .i_status(i_status), .i_data(i_data)
    );

    always #5 m_clk = ~m_clk;
    always @(posedge m_clk) cyc <= cyc + 1;

    // Behavioural master: logs each strobe as {type,byte} (1 start, 2 rw, 3 stop)
    logic [9:0] logq[$];
    logic       tip = 0, nack_a = 0, nack_d = 0, drdy = 0;
    logic       stall = 0, nack_mode = 0;
    logic [7:0] rd_byte = 8'h00;
    int         mst = 0, strobe_cyc = 0;
    assign i_status = {nack_a, nack_d, tip, drdy};
    assign i_data   = rd_byte;

    always @(negedge m_clk) begin
        if (reset) begin
            tip <= 0; nack_a <= 0; nack_d <= 0; drdy <= 0; mst <= 0;
        end else if ((o_start || o_rw_data || o_stop) && !tip && mst == 0) begin
            logq.push_back({o_start ? 2'd1 : (o_rw_data ? 2'd2 : 2'd3), o_addr_cmd_data});
            strobe_cyc <= cyc;
            nack_a <= o_start && nack_mode;
            nack_d <= 1'b0;
            drdy   <= o_start && o_addr_cmd_data[0];
            tip    <= 1'b1;
            mst    <= stall ? 0 : 3;
        end else if (mst > 1) begin
            mst <= mst - 1;
        end else if (mst == 1) begin
            tip <= 1'b0; mst <= 0;
        end else if (!stall && tip) begin
            tip <= 1'b0;
        end
    end

    // Response, accept and strobe-overlap monitors
    int rsp_cnt = 0, rsp_cyc = 0, acc_cnt = 0, acc_cyc = 0, overlap = 0;
    logic [7:0] rsp_d = 0;
    logic [1:0] rsp_e = 0;
    always @(negedge m_clk) begin
        if (rsp_valid) begin
            rsp_cnt <= rsp_cnt + 1; rsp_cyc <= cyc; rsp_d <= rsp_data; rsp_e <= rsp_err;
        end
        if (req_valid && req_ready && !reset) begin
            acc_cnt <= acc_cnt + 1; acc_cyc <= cyc;
        end
        if (32'(o_start) + 32'(o_rw_data) + 32'(o_stop) > 1) overlap <= overlap + 1;
    end

    task automatic tick();
        @(posedge m_clk); #1;
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (acc_cnt < target && n < 200) begin tick(); n++; end
        checks++;
        if (acc_cnt < target) begin failures++; $display("FAIL accept_wait got=%0d want=%0d", acc_cnt, target); end
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 300) begin tick(); n++; end
        checks++;
        if (rsp_cnt < target) begin failures++; $display("FAIL rsp_wait got=%0d want=%0d", rsp_cnt, target); end
    endtask

    task automatic send(input logic rw, input logic [6:0] d, input logic [7:0] r, input logic [7:0] w);
        int a0;
        a0 = acc_cnt;
        req_valid = 1; req_rw = rw; dev_addr = d; reg_addr = r; wr_data = w;
        wait_acc(a0 + 1);
        req_valid = 0;
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL rst_rsp_data got=%h want=00", rsp_data); end
        checks++; if (rsp_err !== 2'b00) begin failures++; $display("FAIL rst_rsp_err got=%b want=00", rsp_err); end
        checks++; if ({o_start, o_rw_data, o_stop} !== 3'b000) begin failures++; $display("FAIL rst_strobes got=%b want=000", {o_start, o_rw_data, o_stop}); end
        checks++; if (o_addr_cmd_data !== 8'h00) begin failures++; $display("FAIL rst_byte got=%h want=00", o_addr_cmd_data); end
    endtask

    task automatic test_write();
        int n0;
        n0 = rsp_cnt; logq.delete();
        send(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_rsp(n0 + 1);
        repeat (5) tick();
        checks++; if (logq.size() !== 4) begin failures++; $display("FAIL wr_nstrobes got=%0d want=4", logq.size()); end
        checks++; if (logq[0] !== 10'h1A0) begin failures++; $display("FAIL wr_start got=%h want=1a0", logq[0]); end
        checks++; if (logq[1] !== 10'h210) begin failures++; $display("FAIL wr_reg got=%h want=210", logq[1]); end
        checks++; if (logq[2] !== 10'h2A5) begin failures++; $display("FAIL wr_data got=%h want=2a5", logq[2]); end
        checks++; if (logq[3][9:8] !== 2'd3) begin failures++; $display("FAIL wr_stop got=%0d want=3", logq[3][9:8]); end
        checks++; if (rsp_cnt !== n0 + 1) begin failures++; $display("FAIL wr_one_rsp got=%0d want=%0d", rsp_cnt, n0 + 1); end
        checks++; if (rsp_e !== 2'b00 || rsp_d !== 8'h00) begin failures++; $display("FAIL wr_rsp got=%b/%h want=00/00", rsp_e, rsp_d); end
    endtask

    task automatic test_read();
        int n0;
        n0 = rsp_cnt; logq.delete(); rd_byte = 8'h3C;
        send(1'b1, 7'h50, 8'h22, 8'h00);
        wait_rsp(n0 + 1);
        checks++; if (logq.size() !== 4) begin failures++; $display("FAIL rd_nstrobes got=%0d want=4", logq.size()); end
        checks++; if (logq[0] !== 10'h1A0) begin failures++; $display("FAIL rd_start got=%h want=1a0", logq[0]); end
        checks++; if (logq[1] !== 10'h222) begin failures++; $display("FAIL rd_reg got=%h want=222", logq[1]); end
        checks++; if (logq[2] !== 10'h1A1) begin failures++; $display("FAIL rd_rstart got=%h want=1a1", logq[2]); end
        checks++; if (logq[3][9:8] !== 2'd3) begin failures++; $display("FAIL rd_stop got=%0d want=3", logq[3][9:8]); end
        checks++; if (rsp_d !== 8'h3C) begin failures++; $display("FAIL rd_data got=%h want=3c", rsp_d); end
        checks++; if (rsp_e !== 2'b00) begin failures++; $display("FAIL rd_err got=%b want=00", rsp_e); end
    endtask

    task automatic test_addr_nack();
        int n0;
        n0 = rsp_cnt; logq.delete(); nack_mode = 1;
        send(1'b1, 7'h50, 8'h22, 8'h00);
        wait_rsp(n0 + 1);
        repeat (10) tick();
        nack_mode = 0;
        checks++; if (logq.size() !== 1) begin failures++; $display("FAIL nack_nstrobes got=%0d want=1", logq.size()); end
        checks++; if (rsp_e !== 2'b01) begin failures++; $display("FAIL nack_err got=%b want=01", rsp_e); end
        checks++; if (rsp_d !== 8'h00) begin failures++; $display("FAIL nack_data got=%h want=00", rsp_d); end
    endtask

    task automatic test_timeout();
        int n0, dt;
        n0 = rsp_cnt; stall = 1;
        send(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_rsp(n0 + 1);
        dt = rsp_cyc - strobe_cyc;
        checks++; if (rsp_e !== 2'b11) begin failures++; $display("FAIL to_err got=%b want=11", rsp_e); end
        checks++; if (dt < 31 || dt > 33) begin failures++; $display("FAIL to_latency got=%0d want=32+-1", dt); end
        checks++; if ({o_start, o_rw_data, o_stop} !== 3'b000) begin failures++; $display("FAIL to_strobes got=%b want=000", {o_start, o_rw_data, o_stop}); end
        stall = 0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        int n0, n;
        n0 = rsp_cnt; logq.delete(); n = 0;
        send(1'b0, 7'h50, 8'h10, 8'hA5);
        while (logq.size() < 3 && n < 100) begin tick(); n++; end
        checks++; if (logq.size() < 3) begin failures++; $display("FAIL rm_reach got=%0d want=3", logq.size()); end
        reset = 1;
        tick();
        checks++; if ({o_start, o_rw_data, o_stop} !== 3'b000) begin failures++; $display("FAIL rm_strobes got=%b want=000", {o_start, o_rw_data, o_stop}); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b want=1", req_ready); end
        reset = 0;
        repeat (20) tick();
        checks++; if (rsp_cnt !== n0) begin failures++; $display("FAIL rm_no_rsp got=%0d want=%0d", rsp_cnt, n0); end
    endtask

    task automatic test_back_to_back();
        int n0, a0, ov0, r1cyc;
        logic [1:0] e1;
        n0 = rsp_cnt; a0 = acc_cnt; ov0 = overlap; logq.delete();
        req_valid = 1; req_rw = 0; dev_addr = 7'h50; reg_addr = 8'h10; wr_data = 8'h5A;
        wait_acc(a0 + 1);
        req_rw = 1; reg_addr = 8'h05; wr_data = 8'h00; rd_byte = 8'h77;
        wait_rsp(n0 + 1);
        r1cyc = rsp_cyc; e1 = rsp_e;
        wait_acc(a0 + 2);
        req_valid = 0;
        checks++; if (acc_cyc !== r1cyc + 1) begin failures++; $display("FAIL b2b_accept_cyc got=%0d want=%0d", acc_cyc, r1cyc + 1); end
        wait_rsp(n0 + 2);
        checks++; if (e1 !== 2'b00) begin failures++; $display("FAIL b2b_err1 got=%b want=00", e1); end
        checks++; if (rsp_e !== 2'b00 || rsp_d !== 8'h77) begin failures++; $display("FAIL b2b_rsp2 got=%b/%h want=00/77", rsp_e, rsp_d); end
        checks++; if (logq.size() !== 8) begin failures++; $display("FAIL b2b_nstrobes got=%0d want=8", logq.size()); end
        checks++; if (overlap !== ov0) begin failures++; $display("FAIL b2b_overlap got=%0d want=%0d", overlap, ov0); end
    endtask

    initial begin
        repeat (3) tick();
        test_reset();
        reset = 0;
        tick();
        test_write();
        test_read();
        test_addr_nack();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
